// File: rtl/mips_uart_tx_port.sv
// mips_uart_tx_port: memory-mapped UART transmitter on the MIPS data-memory port.
//   Stores to BASE_ADDR push WriteData[7:0] into a TX FIFO; loads from BASE_ADDR+4
//   return {24'b0, occupancy[3:0], ovf, busy, empty, full}. A serializer drains the
//   FIFO onto tx at BAUD_DIV clocks per bit (start, 8 data LSB first, [parity], stop).
// Ports: clk, reset (sync, active-high), Address/WriteData/MemWrite/MemRead from the
//   processor, ReadData (combinational status), Selected (address decode hit),
//   tx (registered serial line, idles high), Irq (registered: FIFO empty and idle).
// Optional: define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module mips_uart_tx_port #(
  parameter int          BAUD_DIV   = 434,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Selected,
  output logic        tx,
  output logic        Irq
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);
  localparam logic [AW:0] DEPTH_CNT   = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_PARITY} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          irq_q;
  logic          ovf_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic        fifo_empty, fifo_full, push_req, push_ok, pop, ovf_set, ovf_clr, baud_done;
  logic [7:0]  head;
  logic [6:0]  cnt_ext;
  logic [3:0]  occ;
  logic        unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign head       = mem_q[rd_ptr_q];
  assign push_req   = MemWrite && (Address == BASE_ADDR);
  // A full FIFO still takes the byte if the serializer pops on the same edge.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && !push_ok;
  assign ovf_clr    = MemRead && (Address == STATUS_ADDR);
  assign baud_done  = (cnt_q == BAUD_LAST);

  // Occupancy field is 4 bits wide; saturate for deeper FIFOs.
  assign cnt_ext = 7'(count_q);
  assign occ     = (cnt_ext > 7'd15) ? 4'hF : cnt_ext[3:0];

  assign Selected = (Address == BASE_ADDR) || (Address == STATUS_ADDR);
  assign ReadData = (Address == STATUS_ADDR) ?
                    {24'b0, occ, ovf_q, (state_q != S_IDLE), fifo_empty, fifo_full} : 32'b0;
  assign tx  = tx_q;
  assign Irq = irq_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = S_START;
        end
      end
      S_START: if (baud_done) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (baud_done) begin
        cnt_d   = '0;
        shift_d = shift_q >> 1;
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_done) begin
        cnt_d   = '0;
        state_d = S_STOP;
      end
`endif
      S_STOP: if (baud_done) begin
        cnt_d = '0;
        // Chain straight into the next frame so back-to-back bytes have no idle gap.
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^head : par_q;
`endif

    // tx is registered from the next state so the line never glitches.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= fifo_empty && (state_q == S_IDLE);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      // Set wins over a same-edge clearing read.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= WriteData[7:0];
  end

endmodule

// File: tb/tb_mips_uart_tx_port.sv
module tb_mips_uart_tx_port;
  localparam int          BAUD = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE = 32'h1001_0100;
  localparam logic [31:0] STAT = BASE + 32'd4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FR = FRAME_BITS * BAUD;

  logic        clk, reset, MemWrite, MemRead, Selected, tx, Irq;
  logic [31:0] Address, WriteData, ReadData;

  mips_uart_tx_port #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
    .Selected(Selected), .tx(tx), .Irq(Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: every byte accepted into the FIFO must appear on tx, in order,
  // as one well-formed UART frame.
  logic [7:0] exp_q[$];
  int         rx_starts[$];
  int         cyc = 0;
  bit         rx_active = 0;
  int         rx_k;
  logic [7:0] rx_byte;

  always @(negedge clk) cyc++;

  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      rx_active = 0;
    end else begin
      if (!rx_active && tx === 1'b0) begin
        rx_active = 1;
        rx_k      = 0;
        rx_byte   = 8'h00;
        rx_starts.push_back(cyc);
      end
      if (rx_active) begin
        int slot, pos;
        rx_k++;
        slot = (rx_k - 1) / BAUD;
        pos  = (rx_k - 1) % BAUD;
        if (slot == 0) chk("rx_start_bit", tx, 0);
        else if (slot <= 8) begin
          if (pos == 0) rx_byte[slot-1] = tx;
          else chk("rx_data_stable", tx, rx_byte[slot-1]);
        end
`ifdef UART_TX_PARITY_EN
        else if (slot == 9) chk("rx_parity_bit", tx, ^rx_byte);
`endif
        else chk("rx_stop_bit", tx, 1);
        if (rx_k == FR) begin
          rx_active = 0;
          chk("rx_frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("rx_byte", rx_byte, exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int slot;
    if (k < 1 || k > FR) return 1'b1;
    slot = (k - 1) / BAUD;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic idle_inputs();
    MemWrite = 0; MemRead = 0; Address = 32'h0; WriteData = 32'h0;
  endtask

  task automatic do_reset();
    exp_q.delete();
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1; MemRead = 0;
    if (a == BASE) exp_q.push_back(d[7:0]);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    bit done = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk); #1;
      if (Irq && !rx_active) begin done = 1; break; end
    end
    chk(name, done, 1);
  endtask

  typedef struct {
    logic [31:0] addr; logic [31:0] wdata; logic mw; logic mr;
    logic [31:0] rd; logic sel;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_cnt, low_cnt;
    idle_inputs();
    reset = 1;

    // Reset state
    do_reset();
    Address = STAT; MemRead = 1; #1;
    chk("reset_tx", tx, 1);
    chk("reset_status", ReadData, 32'h2);
    chk("reset_irq", Irq, 1);

    // Address decode table, idle unit
    vecs[0] = '{STAT,                32'h0,  1'b0, 1'b1, 32'h2, 1'b1};
    vecs[1] = '{BASE,                32'h0,  1'b0, 1'b1, 32'h0, 1'b1};
    vecs[2] = '{BASE + 32'd8,        32'h0,  1'b0, 1'b1, 32'h0, 1'b0};
    vecs[3] = '{32'h0,               32'h0,  1'b0, 1'b1, 32'h0, 1'b0};
    vecs[4] = '{BASE - 32'd4,        32'h0,  1'b0, 1'b1, 32'h0, 1'b0};
    vecs[5] = '{STAT,                32'hFF, 1'b1, 1'b0, 32'h2, 1'b1};
    vecs[6] = '{STAT,                32'h0,  1'b0, 1'b1, 32'h2, 1'b1};
    vecs[7] = '{BASE ^ 32'h8000_0000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[8] = '{STAT + 32'h1000_0000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[9] = '{BASE + 32'd1,        32'h0,  1'b0, 1'b1, 32'h0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Address = vecs[i].addr; WriteData = vecs[i].wdata;
      MemWrite = vecs[i].mw; MemRead = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d_rdata", i), ReadData, vecs[i].rd);
      chk($sformatf("vec%0d_sel", i), Selected, vecs[i].sel);
      chk($sformatf("vec%0d_irq", i), Irq, 1);
    end
    @(negedge clk);
    idle_inputs();

    // Single byte: exact waveform cycle by cycle
    @(negedge clk);
    drive_store(BASE, 32'hFFFF_FF55);
    @(negedge clk);
    idle_inputs(); #1;
    chk("sb_tx_k0", tx, 1);
    for (int k = 1; k <= FR + 2; k++) begin
      @(negedge clk); #1;
      chk($sformatf("sb_tx_k%0d", k), tx, exp_tx(8'h55, k));
      if (k == FR + 1) chk("sb_irq_lag", Irq, 0);
      if (k == FR + 2) chk("sb_irq_set", Irq, 1);
    end
    wait_idle(FR, "sb_idle");

    // Back-to-back frames
    do_reset();
    rx_starts.delete();
    drive_store(BASE, 32'h41);
    @(negedge clk);
    drive_store(BASE, 32'h42);
    @(negedge clk);
    idle_inputs();
    Address = STAT; MemRead = 1;
    busy_cnt = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      #1;
      if (ReadData[2]) busy_cnt++;
      else if (busy_cnt > 0) break;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", busy_cnt, 2 * FR);
    idle_inputs();
    wait_idle(3 * FR, "b2b_idle");
    chk("b2b_frames", rx_starts.size(), 2);
    if (rx_starts.size() >= 2) chk("b2b_gap", rx_starts[1] - rx_starts[0], FR);
    chk("b2b_drained", exp_q.size(), 0);

    // Overflow: 10 consecutive stores, 10th dropped
    do_reset();
    for (int i = 0; i < 10; i++) begin
      Address = BASE; WriteData = 32'hDEAD_BE00 | (32'h30 + i); MemWrite = 1;
      if (i < 9) exp_q.push_back(8'(8'h30 + i));
      @(negedge clk);
    end
    idle_inputs();
    Address = STAT; MemRead = 1; #1;
    chk("ovf_status", ReadData, 32'h8D);
    @(negedge clk); #1;
    chk("ovf_cleared", ReadData, 32'h85);
    idle_inputs();
    wait_idle(10 * FR + 50, "ovf_idle");
    chk("ovf_drained", exp_q.size(), 0);

    // Push onto a full FIFO on the STOP->START pop edge
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_store(BASE, 32'h60 + i);
      @(negedge clk);
    end
    idle_inputs();
    Address = STAT; #1;
    chk("pp_full", ReadData, 32'h85);
    repeat (FR - 8) @(negedge clk);
    #1;
    chk("pp_pre_edge", ReadData, 32'h85);
    drive_store(BASE, 32'h69);
    @(negedge clk);
    idle_inputs();
    Address = STAT; #1;
    chk("pp_post_edge", ReadData, 32'h85);
    wait_idle(10 * FR + 50, "pp_idle");
    chk("pp_drained", exp_q.size(), 0);

    // Reset during DATA bit 3
    do_reset();
    drive_store(BASE, 32'h5A);
    @(negedge clk);
    drive_store(BASE, 32'hA5);
    @(negedge clk);
    idle_inputs();
    repeat (16) @(negedge clk);
    reset = 1;
    exp_q.delete();
    @(negedge clk); #1;
    chk("rmf_tx", tx, 1);
    reset = 0;
    Address = STAT; MemRead = 1; #1;
    chk("rmf_status", ReadData, 32'h2);
    chk("rmf_irq", Irq, 1);
    idle_inputs();
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (tx !== 1'b1) low_cnt++;
    end
    chk("rmf_quiet", low_cnt, 0);

    // Randomized traffic: up to 9 pushes per burst never overflow from idle
    do_reset();
    for (int r = 0; r < 12; r++) begin
      int npush, done, op;
      npush = $urandom_range(1, 9);
      done  = 0;
      while (done < npush) begin
        op = $urandom_range(0, 4);
        idle_inputs();
        case (op)
          0: begin drive_store(BASE, $urandom); done++; end
          1: drive_store(STAT, $urandom);
          2: begin Address = STAT; MemRead = 1; end
          3: Address = $urandom;
          default: drive_store(BASE + 32'd8, $urandom);
        endcase
        #1;
        chk("rnd_selected", Selected, (Address == BASE) || (Address == STAT));
        if (op == 2) chk("rnd_no_ovf", ReadData[3], 0);
        @(negedge clk);
      end
      idle_inputs();
      wait_idle(9 * FR + 50, "rnd_idle");
      chk("rnd_drained", exp_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_uart_tx_port.md
# mips_uart_tx_port

Memory-mapped UART transmit peripheral sitting directly downstream of the single-cycle MIPS processor's data-memory port. It decodes processor stores and loads to two word addresses: stores push bytes into an internal FIFO, and loads return a status word. A serializer drains the FIFO onto a single `tx` line with programmable baud. Software can therefore print characters with `sw` and poll readiness with `lw`.

## Interface
- `BAUD_DIV`, 434: clock cycles per serial bit (434 = 115200 baud at 50 MHz); legal range 2..65535.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, 2..64.
- `BASE_ADDR`, 32'h1001_0100: address of TX_DATA; STATUS is `BASE_ADDR+4`.

- `clk` in 1: system clock, shared with the processor.
- `reset` in 1: synchronous, active-high reset.
- `Address` in 32: processor data address (ALU result).
- `WriteData` in 32: store data (rt contents); only bits [7:0] are used.
- `MemWrite` in 1: store strobe from Control.
- `MemRead` in 1: load strobe from Control.
- `ReadData` out 32: combinational load data; 0 when not selected.
- `Selected` out 1: high when `Address` equals TX_DATA or STATUS; the top level uses it to steer the write-back mux away from DataMemory.
- `tx` out 1: serial output; idles high.
- `Irq` out 1: registered; high while the FIFO is empty and the serializer is idle.

## Operation
- **Push.** At a rising edge with `MemWrite` high and `Address==BASE_ADDR`, `WriteData[7:0]` is pushed into the FIFO.
- **Full FIFO.** A push is accepted if the FIFO is not full, or if a pop occurs on the same edge (count unchanged). Otherwise the byte is dropped and sticky `ovf` is set.
- **STATUS read.** Combinational `ReadData` = {24'b0, count[3:0] saturated at 15, ovf, busy, empty, full}:
  - bit0 full
  - bit1 empty
  - bit2 busy (FSM not IDLE)
  - bit3 ovf
  - bits[7:4] occupancy
- **Clearing `ovf`.** `ovf` clears at the edge where `MemRead` is high and `Address==BASE_ADDR+4`. If an overflow occurs on that same edge, set wins.
- **Other accesses.** Loads from TX_DATA return 0. Stores to STATUS are ignored.
- **FSM.** Uses one baud counter (0..BAUD_DIV-1) and a bit index (0..7).
  - IDLE: `tx`=1. If FIFO non-empty: pop the head into the shift register, counter=0, go to START.
  - START: `tx`=0 for BAUD_DIV cycles, then DATA.
  - DATA: `tx`=shift[0], LSB first, for BAUD_DIV cycles per bit. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: `tx`=even parity of the byte for BAUD_DIV cycles, then STOP.
  - STOP: `tx`=1 for BAUD_DIV cycles, then IDLE. If the FIFO is non-empty at that edge, pop directly and enter START, with no idle gap.
- **Registered output.** `tx` is a register driven from the next-state decode, so it is glitch-free.
- **FIFO structure.** Circular buffer with read/write pointers of width log2(FIFO_DEPTH). Pointers wrap modulo depth. A separate count of width log2(FIFO_DEPTH)+1 tracks occupancy.

## Timing
- **Reset values.** At the first edge with `reset` high: `tx`=1, FSM=IDLE, FIFO empty (count 0, pointers 0), `ovf`=0, `Irq`=1, counter=0. `ReadData` then reads 32'h0000_0002 at STATUS.
- **Reset mid-frame.** The frame is aborted, `tx`=1 on the next edge, and queued bytes are discarded.
- **Start latency.** A store at edge E0 into an empty FIFO while IDLE pops at E1; `tx` falls after E1, i.e. 1 cycle of latency.
- **Frame length.** 10×BAUD_DIV cycles, or 11×BAUD_DIV with parity.
- **Back-to-back frames.** Contiguous; the stop bit is exactly BAUD_DIV cycles.
- **`Irq` timing.** Lags the status condition by one cycle.
- **Reads.** Status reads reflect register state before the current edge. A push and a STATUS read in the same instruction are impossible, since a single-cycle instruction is either a store or a load.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in, and the frame is start, 8 data, even parity, stop.
  - Undefined: no PARITY state or parity logic; the frame is start, 8 data, stop.

## Test plan
- **Reset.** `reset` high for 2 cycles then low → `tx`=1, STATUS read = 32'h0000_0002, `Irq`=1.
- **Single byte.** BAUD_DIV=4, store 32'hFFFF_FF55 to 0x1001_0100 → `tx` low 4 cycles starting 1 cycle later, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high. Total 40 cycles (44 with parity; parity bit=0).
- **Overflow.** FIFO_DEPTH=8, 10 stores in consecutive cycles → the first byte pops after 1 cycle, 8 more are accepted, and the 10th is dropped. STATUS reads 32'h0000_008D (count 8, ovf, busy, full). The next STATUS read clears ovf, giving 32'h0000_0085.
- **Back-to-back.** Bytes 0x41, 0x42 stored back-to-back → the two frames are contiguous with no extra idle cycles, and `busy` stays high for 80 cycles.
- **Push/pop on the same edge.** FIFO full and a store lands on the STOP→START pop edge → the byte is accepted, count stays 8, and ovf stays 0.
- **Reset mid-frame.** Reset asserted during DATA bit 3 → `tx`=1 next cycle, FIFO empty, and no further frames after release.
